// File: rtl/csi2_pkt_parser.sv
// ---------------------------------------------------------------------------
// csi2_pkt_parser
//   CSI-2 packet layer for the ISP front end. Takes the merged byte stream
//   after lane merging, parses short/long packet headers, tracks the line
//   index per virtual channel, packs long-packet payload into OUT_BYTES-wide
//   words (LSB byte first) and checks the payload CRC-16.
//
//   Build option: define CSI2_HDR_ECC_EN to check the header ECC byte against
//   the 6-bit CSI-2 Hamming code over DI/WC. When undefined, the ECC byte is
//   consumed and ignored.
//
// Ports
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   in_byte_i/valid_i/sop_i  merged byte stream; sop marks header byte 0
//   out_data_o/keep_o        payload word and contiguous byte mask
//   out_valid_o/sop_o/eop_o  word strobe, first/last word of a long packet
//   out_vc_o/dt_o/line_o     VC, DT and line index of the current long packet
//   short_valid_o/vc_o/dt_o/data_o  accepted short packet (1-cycle pulse)
//   hdr_err_o, crc_err_o, trunc_err_o  1-cycle error pulses
//   crc_err_cnt_o            saturating count of crc_err_o pulses
// ---------------------------------------------------------------------------
module csi2_pkt_parser #(
  parameter int OUT_BYTES = 4,
  parameter int NUM_VC    = 4,
  parameter int WC_MAX    = 16384,
  parameter int LINE_W    = 13
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [7:0]             in_byte_i,
  input  logic                   in_valid_i,
  input  logic                   in_sop_i,
  output logic [8*OUT_BYTES-1:0] out_data_o,
  output logic [OUT_BYTES-1:0]   out_keep_o,
  output logic                   out_valid_o,
  output logic                   out_sop_o,
  output logic                   out_eop_o,
  output logic [1:0]             out_vc_o,
  output logic [5:0]             out_dt_o,
  output logic [LINE_W-1:0]      out_line_o,
  output logic                   short_valid_o,
  output logic [1:0]             short_vc_o,
  output logic [5:0]             short_dt_o,
  output logic [15:0]            short_data_o,
  output logic                   hdr_err_o,
  output logic                   crc_err_o,
  output logic                   trunc_err_o,
  output logic [15:0]            crc_err_cnt_o
);

  localparam int IW = $clog2(OUT_BYTES + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_CRC, S_DROP} state_t;

  // Reflected CRC-16/CCITT step, one byte LSB first.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

`ifdef CSI2_HDR_ECC_EN
  // Each parity bit is the XOR of the header bits selected by its mask.
  function automatic logic [5:0] ecc_calc(input logic [23:0] h);
    logic [5:0] p;
    p[0] = ^(h & 24'hF12CB7);
    p[1] = ^(h & 24'hF2555B);
    p[2] = ^(h & 24'h749A6D);
    p[3] = ^(h & 24'hB8E38E);
    p[4] = ^(h & 24'hDF03F0);
    p[5] = ^(h & 24'hEFFC00);
    return p;
  endfunction
`endif

  state_t state_q, state_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [7:0]  di_q, di_d, wcl_q, wcl_d, wch_q, wch_d;
  logic [16:0] rem_q, rem_d;            // payload bytes left, or bytes left to drop
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crcb_q, crcb_d;          // first (low) received CRC byte
  logic        cidx_q, cidx_d;
  logic [OUT_BYTES-1:0][7:0] pk_q, pk_d;
  logic [IW-1:0] idx_q, idx_d;
  logic        first_q, first_d;
  logic [NUM_VC-1:0][LINE_W-1:0] line_cnt_q, line_cnt_d;

  logic [OUT_BYTES-1:0][7:0] odata_q, odata_d;
  logic [OUT_BYTES-1:0] okeep_q, okeep_d;
  logic        ov_q, ov_d, osop_q, osop_d, oeop_q, oeop_d;
  logic [1:0]  ovc_q, ovc_d;
  logic [5:0]  odt_q, odt_d;
  logic [LINE_W-1:0] oline_q, oline_d;
  logic        sv_q, sv_d;
  logic [1:0]  svc_q, svc_d;
  logic [5:0]  sdt_q, sdt_d;
  logic [15:0] sdata_q, sdata_d;
  logic        herr_q, herr_d, cerr_q, cerr_d, terr_q, terr_d;
  logic [15:0] ccnt_q, ccnt_d;

  // Header decode, valid while the ECC byte is on the input.
  logic [15:0] wc;
  logic [1:0]  vc;
  logic        is_short, ecc_bad, hdr_bad, pay_last;
  logic [LINE_W-1:0] line_sel;
  logic [OUT_BYTES-1:0][7:0] word_nxt;
  logic [OUT_BYTES-1:0] add_keep, flush_keep;

  always_comb begin
    wc       = {wch_q, wcl_q};
    vc       = di_q[7:6];
    is_short = (di_q[5:4] == 2'b00);
`ifdef CSI2_HDR_ECC_EN
    ecc_bad  = (in_byte_i != {2'b00, ecc_calc({wch_q, wcl_q, di_q})});
`else
    ecc_bad  = 1'b0;
`endif
    // WC is a frame/line number for short packets, so the range check is long-only.
    hdr_bad  = ecc_bad || (int'(vc) >= NUM_VC) || (!is_short && (32'(wc) > WC_MAX));
    pay_last = (rem_q == 17'd1);
    line_sel = '0;
    for (int v = 0; v < NUM_VC; v++) if (int'(vc) == v) line_sel = line_cnt_q[v];
    word_nxt = pk_q;
    for (int j = 0; j < OUT_BYTES; j++) begin
      if (j == int'(idx_q)) word_nxt[j] = in_byte_i;
      add_keep[j]   = (j <= int'(idx_q));
      flush_keep[j] = (j <  int'(idx_q));
    end
  end

  always_comb begin
    state_d = state_q;  hcnt_d = hcnt_q;  di_d = di_q;  wcl_d = wcl_q;  wch_d = wch_q;
    rem_d = rem_q;  crc_d = crc_q;  crcb_d = crcb_q;  cidx_d = cidx_q;
    pk_d = pk_q;  idx_d = idx_q;  first_d = first_q;  line_cnt_d = line_cnt_q;
    odata_d = odata_q;  okeep_d = okeep_q;  ovc_d = ovc_q;  odt_d = odt_q;  oline_d = oline_q;
    ov_d = 1'b0;  osop_d = 1'b0;  oeop_d = 1'b0;
    sv_d = 1'b0;  svc_d = svc_q;  sdt_d = sdt_q;  sdata_d = sdata_q;
    herr_d = 1'b0;  cerr_d = 1'b0;  terr_d = 1'b0;  ccnt_d = ccnt_q;

    if (in_valid_i) begin
      if (in_sop_i) begin
        // Sync always restarts the header; an unfinished packet is truncated.
        if (state_q != S_IDLE) terr_d = 1'b1;
        if (state_q == S_PAY && idx_q != '0) begin
          ov_d = 1'b1;  osop_d = first_q;  oeop_d = 1'b1;
          odata_d = pk_q;  okeep_d = flush_keep;
        end
        di_d = in_byte_i;  hcnt_d = 2'd1;  state_d = S_HDR;
      end else begin
        case (state_q)
          S_HDR: begin
            hcnt_d = hcnt_q + 2'd1;
            case (hcnt_q)
              2'd1: wcl_d = in_byte_i;
              2'd2: wch_d = in_byte_i;
              default: begin                       // ECC byte
                if (hdr_bad) begin
                  herr_d = 1'b1;
                  if (is_short) state_d = S_IDLE;
                  else begin
                    state_d = S_DROP;
                    rem_d   = {1'b0, wc} + 17'd2;  // payload plus CRC
                  end
                end else if (is_short) begin
                  sv_d = 1'b1;  svc_d = vc;  sdt_d = di_q[5:0];  sdata_d = wc;
                  if (di_q[5:0] == 6'h00)
                    for (int v = 0; v < NUM_VC; v++) if (int'(vc) == v) line_cnt_d[v] = '0;
                  state_d = S_IDLE;
                end else begin
                  ovc_d = vc;  odt_d = di_q[5:0];  oline_d = line_sel;
                  crc_d = 16'hFFFF;  pk_d = '0;  idx_d = '0;  first_d = 1'b1;  cidx_d = 1'b0;
                  rem_d = {1'b0, wc};
                  state_d = (wc == 16'd0) ? S_CRC : S_PAY;
                end
              end
            endcase
          end
          S_PAY: begin
            crc_d = crc_upd(crc_q, in_byte_i);
            rem_d = rem_q - 17'd1;
            if ((int'(idx_q) == OUT_BYTES - 1) || pay_last) begin
              ov_d = 1'b1;  osop_d = first_q;  oeop_d = pay_last;
              odata_d = word_nxt;  okeep_d = add_keep;
              first_d = 1'b0;  pk_d = '0;  idx_d = '0;
            end else begin
              pk_d  = word_nxt;
              idx_d = idx_q + IW'(1);
            end
            if (pay_last) begin
              state_d = S_CRC;  cidx_d = 1'b0;
            end
          end
          S_CRC: begin
            if (!cidx_q) begin
              crcb_d = in_byte_i;  cidx_d = 1'b1;
            end else begin
              if ({in_byte_i, crcb_q} != crc_q) begin
                cerr_d = 1'b1;
                if (ccnt_q != 16'hFFFF) ccnt_d = ccnt_q + 16'd1;
              end
              for (int v = 0; v < NUM_VC; v++)
                if (int'(ovc_q) == v && line_cnt_q[v] != '1) line_cnt_d[v] = line_cnt_q[v] + LINE_W'(1);
              state_d = S_IDLE;
            end
          end
          S_DROP: begin
            rem_d = rem_q - 17'd1;
            if (rem_q == 17'd1) state_d = S_IDLE;
          end
          default: ;                               // IDLE waits for sync
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;  hcnt_q <= '0;  di_q <= '0;  wcl_q <= '0;  wch_q <= '0;
      rem_q <= '0;  crc_q <= 16'hFFFF;  crcb_q <= '0;  cidx_q <= 1'b0;
      pk_q <= '0;  idx_q <= '0;  first_q <= 1'b0;  line_cnt_q <= '0;
      odata_q <= '0;  okeep_q <= '0;  ov_q <= 1'b0;  osop_q <= 1'b0;  oeop_q <= 1'b0;
      ovc_q <= '0;  odt_q <= '0;  oline_q <= '0;
      sv_q <= 1'b0;  svc_q <= '0;  sdt_q <= '0;  sdata_q <= '0;
      herr_q <= 1'b0;  cerr_q <= 1'b0;  terr_q <= 1'b0;  ccnt_q <= '0;
    end else begin
      state_q <= state_d;  hcnt_q <= hcnt_d;  di_q <= di_d;  wcl_q <= wcl_d;  wch_q <= wch_d;
      rem_q <= rem_d;  crc_q <= crc_d;  crcb_q <= crcb_d;  cidx_q <= cidx_d;
      pk_q <= pk_d;  idx_q <= idx_d;  first_q <= first_d;  line_cnt_q <= line_cnt_d;
      odata_q <= odata_d;  okeep_q <= okeep_d;  ov_q <= ov_d;  osop_q <= osop_d;  oeop_q <= oeop_d;
      ovc_q <= ovc_d;  odt_q <= odt_d;  oline_q <= oline_d;
      sv_q <= sv_d;  svc_q <= svc_d;  sdt_q <= sdt_d;  sdata_q <= sdata_d;
      herr_q <= herr_d;  cerr_q <= cerr_d;  terr_q <= terr_d;  ccnt_q <= ccnt_d;
    end
  end

  assign out_data_o    = odata_q;
  assign out_keep_o    = okeep_q;
  assign out_valid_o   = ov_q;
  assign out_sop_o     = osop_q;
  assign out_eop_o     = oeop_q;
  assign out_vc_o      = ovc_q;
  assign out_dt_o      = odt_q;
  assign out_line_o    = oline_q;
  assign short_valid_o = sv_q;
  assign short_vc_o    = svc_q;
  assign short_dt_o    = sdt_q;
  assign short_data_o  = sdata_q;
  assign hdr_err_o     = herr_q;
  assign crc_err_o     = cerr_q;
  assign trunc_err_o   = terr_q;
  assign crc_err_cnt_o = ccnt_q;

endmodule
